alu_decoder_mc: RTL

- Registered, multi-cycle-aware ALU/MDU control decoder for the next processor generation.
- Decodes the full RV32I ALU set plus the RV32M multiply/divide set into a CTRL_W-bit control code.
- Holds each decoded result behind a valid/ready handshake.
- For M-extension ops, sequences a fixed-latency busy window for the multiply/divide unit. Sits between the main control decoder and the execute stage.

---
 rtl/alu_decoder_mc_if.sv | 30 +++
 rtl/alu_decoder_mc.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_decoder_mc_if.sv
// alu_decoder_mc_if: request/response bundle for the ALU/MDU control decoder.
// slave = decoder view, master = upstream decoder plus execute stage view.
interface alu_decoder_mc_if #(
    parameter int CTRL_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [1:0]        alu_op;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alu_control;
    logic              illegal;
    logic              mdu_start;
    logic              mdu_busy;

    modport slave (
        input  in_valid, opcode, funct7, funct3, alu_op, out_ready,
        output in_ready, out_valid, alu_control, illegal,
        output mdu_start, mdu_busy
    );

    modport master (
        output in_valid, opcode, funct7, funct3, alu_op, out_ready,
        input  in_ready, out_valid, alu_control, illegal,
        input  mdu_start, mdu_busy
    );
endinterface

// File: rtl/alu_decoder_mc.sv
// alu_decoder_mc: registered RV32I/RV32M ALU control decoder with MDU busy window.
// Ports: clk, rst_n (async low), flush (sync kill), bus (alu_decoder_mc_if.slave).
module alu_decoder_mc #(
    parameter int CTRL_W     = 5,
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    alu_decoder_mc_if.slave        bus
);
    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

    localparam logic [4:0] C_ADD  = 5'b00000;
    localparam logic [4:0] C_SUB  = 5'b00001;
    localparam logic [4:0] C_OR   = 5'b00010;
    localparam logic [4:0] C_AND  = 5'b00011;
    localparam logic [4:0] C_XOR  = 5'b00100;
    localparam logic [4:0] C_SLT  = 5'b00101;
    localparam logic [4:0] C_PASS = 5'b00110;
    localparam logic [4:0] C_SLTU = 5'b00111;
    localparam logic [4:0] C_SLL  = 5'b01000;
    localparam logic [4:0] C_SRL  = 5'b01001;
    localparam logic [4:0] C_SRA  = 5'b01010;

    typedef enum logic [1:0] {
        IDLE,
        VALID,
        MDU_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              ill_q;
    logic              start_q;

    logic [4:0] dec_code;
    logic       dec_ill;
    logic       dec_mop;
    logic       is_r, is_m, f7_base, f7_alt;
    logic       is_shift, r_bad, shift_bad;
    logic       accept;

    assign is_r     = (bus.opcode == 7'b0110011);
    assign f7_base  = (bus.funct7 == 7'b0000000);
    assign f7_alt   = (bus.funct7 == 7'b0100000);
    assign is_m     = is_r && (bus.funct7 == 7'b0000001);
    assign is_shift = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);

    // I-type funct7 carries immediate bits, so only R-type and shifts
    // constrain it.
    assign r_bad = is_r && ((!f7_base && !f7_alt) ||
                   (f7_alt && bus.funct3 != 3'b000 && bus.funct3 != 3'b101));
    assign shift_bad = is_shift && ((!f7_base && !f7_alt) ||
                       (f7_alt && bus.funct3 == 3'b001));

    always_comb begin
        dec_code = C_ADD;
        dec_ill  = 1'b0;
        dec_mop  = 1'b0;
        unique case (bus.alu_op)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            2'b11: dec_code = C_PASS;
            2'b10: begin
                if (is_m) begin
                    if (ENABLE_M != 0) begin
                        dec_code = {2'b10, bus.funct3};
                        dec_mop  = 1'b1;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end else begin
                    unique case (bus.funct3)
                        3'b000: dec_code = (bus.opcode[5] && f7_alt) ? C_SUB : C_ADD;
                        3'b001: dec_code = C_SLL;
                        3'b010: dec_code = C_SLT;
                        3'b011: dec_code = C_SLTU;
                        3'b100: dec_code = C_XOR;
                        3'b101: dec_code = f7_alt ? C_SRA : C_SRL;
                        3'b110: dec_code = C_OR;
                        3'b111: dec_code = C_AND;
                    endcase
                    if (r_bad || shift_bad) begin
                        dec_ill  = 1'b1;
                        dec_code = C_ADD;
                    end
                end
            end
        endcase
    end

    assign bus.in_ready = !flush &&
        (state_q == IDLE || (state_q == VALID && bus.out_ready));
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept)
                        state_d = dec_mop ? MDU_WAIT : VALID;
                end
                VALID: begin
                    if (bus.out_ready)
                        state_d = accept ? (dec_mop ? MDU_WAIT : VALID) : IDLE;
                end
                MDU_WAIT: begin
                    if (cnt_q == '0)
                        state_d = VALID;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
            start_q <= 1'b0;
        end else if (flush) begin
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= accept && dec_mop;
            if (accept) begin
                ctrl_q <= CTRL_W'(dec_code);
                ill_q  <= dec_ill;
            end
            if (accept && dec_mop)
                cnt_q <= bus.funct3[2] ? DIV_LD : MUL_LD;
            else if (state_q == MDU_WAIT && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    assign bus.out_valid   = (state_q == VALID);
    assign bus.mdu_busy    = (state_q == MDU_WAIT);
    assign bus.mdu_start   = start_q;
    assign bus.alu_control = ctrl_q;
    assign bus.illegal     = ill_q;
endmodule
